// File: rtl/geometry_mem_server.sv
// Triangle geometry store: clears itself after reset, then serves processor writes
// and in-order, credit-limited reads with a fixed two-cycle latency into a 4-entry FIFO.
module geometry_mem_server #(
  parameter int DATA_WIDTH = 384,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic [ADDR_WIDTH-1:0] rd_rsp_addr,
  output logic                  mem_ready,
  output logic [ADDR_WIDTH:0]   geo_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_SLOT = IDX_W'(DEPTH - 1);
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [IDX_W-1:0]      clr_ptr_r;
  logic                  mem_ready_r;
  logic [ADDR_WIDTH:0]   geo_count_r;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  clear_en_s;
  logic                  serve_s;
  logic                  wr_fire_s;
  logic                  wr_in_range_s;
  logic [ADDR_WIDTH:0]   wr_addr_inc_s;
  logic                  credit_ok_s;
  logic                  rd_req_ready_s;
  logic                  rd_fire_s;
  logic                  mem_we_s;
  logic [IDX_W-1:0]      mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  logic                  s1_valid_r;
  logic                  s1_in_range_r;
  logic [ADDR_WIDTH-1:0] s1_addr_r;
  logic [DATA_WIDTH-1:0] rd_data_s;

  logic [DATA_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [1:0]            fifo_wr_ptr_r;
  logic [1:0]            fifo_rd_ptr_r;
  logic [2:0]            fifo_count_r;
  logic [2:0]            inflight_s;
  logic                  push_s;
  logic                  pop_s;

  // State register, clear pointer and registered ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CLEAR;
      clr_ptr_r   <= '0;
      mem_ready_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      mem_ready_r <= (state_next_s == SERVE);
      if (clear_en_s && (clr_ptr_r != LAST_SLOT)) begin
        clr_ptr_r <= clr_ptr_r + IDX_W'(1);
      end else begin
        clr_ptr_r <= '0;
      end
    end
  end

  // Next-state logic: CLEAR walks every slot once, SERVE holds until reset
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clr_ptr_r == LAST_SLOT) begin
          state_next_s = SERVE;
        end else begin
          state_next_s = CLEAR;
        end
      end
      SERVE:   state_next_s = SERVE;
      default: state_next_s = CLEAR;
    endcase
  end

  // Output decode of the controller state
  always_comb begin
    clear_en_s = 1'b0;
    serve_s    = 1'b0;
    case (state_r)
      CLEAR: begin
        clear_en_s = 1'b1;
        serve_s    = 1'b0;
      end
      SERVE: begin
        clear_en_s = 1'b0;
        serve_s    = 1'b1;
      end
      default: begin
        clear_en_s = 1'b0;
        serve_s    = 1'b0;
      end
    endcase
  end

  // Handshakes; writes win over reads and reads are limited to FIFO credits
  always_comb begin
    inflight_s     = {2'b00, s1_valid_r};
    credit_ok_s    = ((inflight_s + fifo_count_r) < 3'd4);
    wr_fire_s      = wr_valid && serve_s;
    wr_in_range_s  = ({1'b0, wr_addr} < DEPTH_W);
    wr_addr_inc_s  = {1'b0, wr_addr} + (ADDR_WIDTH+1)'(1);
    rd_req_ready_s = serve_s && !wr_valid && credit_ok_s;
    rd_fire_s      = rd_req_valid && rd_req_ready_s;
  end

  // Memory write port shared by the clear sweep and processor writes
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (rst) begin
      mem_we_s = 1'b0;
    end else if (clear_en_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_ptr_r;
      mem_wdata_s = '0;
    end else if (wr_fire_s && wr_in_range_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wr_addr[IDX_W-1:0];
      mem_wdata_s = wr_data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Geometry storage array
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read address stage; out-of-range requests are remembered so they return zero
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r    <= 1'b0;
      s1_in_range_r <= 1'b0;
      s1_addr_r     <= '0;
    end else begin
      s1_valid_r    <= rd_fire_s;
      s1_in_range_r <= ({1'b0, rd_req_addr} < DEPTH_W);
      s1_addr_r     <= rd_req_addr;
    end
  end

  // Memory read data feeding the FIFO (the FIFO entry is the output register)
  always_comb begin
    if (s1_in_range_r) begin
      rd_data_s = mem_r[s1_addr_r[IDX_W-1:0]];
    end else begin
      rd_data_s = '0;
    end
  end

  assign push_s = s1_valid_r;
  assign pop_s  = (fifo_count_r != 3'd0) && rd_rsp_ready;

  // Response FIFO; entries never move, so the head stays stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_ptr_r <= 2'd0;
      fifo_rd_ptr_r <= 2'd0;
      fifo_count_r  <= 3'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= '0;
        fifo_addr_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_data_r[fifo_wr_ptr_r] <= rd_data_s;
        fifo_addr_r[fifo_wr_ptr_r] <= s1_addr_r;
        fifo_wr_ptr_r              <= fifo_wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        fifo_rd_ptr_r <= fifo_rd_ptr_r + 2'd1;
      end
      fifo_count_r <= fifo_count_r + {2'b00, push_s} - {2'b00, pop_s};
    end
  end

  // High-water mark of committed in-range writes
  always_ff @(posedge clk) begin
    if (rst) begin
      geo_count_r <= '0;
    end else if (wr_fire_s && wr_in_range_s && (wr_addr_inc_s > geo_count_r)) begin
      geo_count_r <= wr_addr_inc_s;
    end
  end

  assign wr_ready     = serve_s;
  assign rd_req_ready = rd_req_ready_s;
  assign rd_rsp_valid = (fifo_count_r != 3'd0);
  assign rd_rsp_data  = fifo_data_r[fifo_rd_ptr_r];
  assign rd_rsp_addr  = fifo_addr_r[fifo_rd_ptr_r];
  assign mem_ready    = mem_ready_r;
  assign geo_count    = geo_count_r;

endmodule

// File: tb/tb_geometry_mem_server.sv
// Randomized and directed bench for geometry_mem_server against a queue-based
// reference model (slot 16..31 exercises out-of-range addressing).
module tb_geometry_mem_server;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_rsp_valid;
  logic          rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic [AW-1:0] rd_rsp_addr;
  logic          mem_ready;
  logic [AW:0]   geo_count;

  geometry_mem_server #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data(rd_rsp_data), .rd_rsp_addr(rd_rsp_addr),
    .mem_ready(mem_ready), .geo_count(geo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] mdl_mem [DP];
  logic [AW:0]   mdl_geo;
  int            clr_left;
  int            cyc;
  int            n_vec;
  int            n_err;
  bit            rd_fired;
  bit            low_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    clr_left = DP;
    exp_q.delete();
    mdl_geo = '0;
    for (int i = 0; i < DP; i++) mdl_mem[i] = '0;
  endtask

  // One clock cycle: inputs are already driven; sample at negedge, update model, advance.
  task automatic cycle();
    bit   serve;
    bit   exp_rrdy;
    rsp_t r;
    @(negedge clk);
    serve    = (clr_left == 0);
    exp_rrdy = serve && !wr_valid && (exp_q.size() < 4);
    check("mem_ready", 64'(mem_ready), 64'(serve));
    check("wr_ready", 64'(wr_ready), 64'(serve));
    check("rd_req_ready", 64'(rd_req_ready), 64'(exp_rrdy));
    check("geo_count", 64'(geo_count), 64'(mdl_geo));
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      check("rsp_valid", 64'(rd_rsp_valid), 64'd1);
      check("rsp_data", rd_rsp_data, exp_q[0].data);
      check("rsp_addr", 64'(rd_rsp_addr), 64'(exp_q[0].addr));
      if (rd_rsp_ready) void'(exp_q.pop_front());
    end else begin
      check("rsp_idle", 64'(rd_rsp_valid), 64'd0);
    end
    rd_fired = 1'b0;
    if (rst) begin
      model_reset();
    end else if (serve) begin
      if (wr_valid && wr_addr < DP) begin
        mdl_mem[wr_addr] = wr_data;
        if (({1'b0, wr_addr} + 1) > mdl_geo) mdl_geo = {1'b0, wr_addr} + 1;
      end
      if (rd_req_valid && exp_rrdy) begin
        r.addr = rd_req_addr;
        r.data = (rd_req_addr < DP) ? mdl_mem[rd_req_addr] : '0;
        r.due  = cyc + 2;
        exp_q.push_back(r);
        rd_fired = 1'b1;
      end
    end else begin
      clr_left--;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wr_valid = 1'b0; rd_req_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rd_req_addr = '0;
  endtask

  initial begin
    int idx;
    n_vec = 0; n_err = 0; cyc = 0;
    idle_inputs();
    rd_rsp_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Clear window: ready must stay low for exactly DP cycles
    for (int i = 0; i < DP + 3; i++) cycle();

    // Back-to-back reads of every slot after clear: all zero, one per cycle
    rd_req_valid = 1'b1;
    for (int a = 0; a < DP; a++) begin
      rd_req_addr = AW'(a);
      cycle();
      check("b2b_issue", 64'(rd_fired), 64'd1);
    end
    rd_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Write then immediate read of the same slot
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 64'hA5;
    cycle();
    wr_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 5'd3;
    cycle();
    rd_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("geo_after_a5", 64'(geo_count), 64'd4);

    // Credit limit with a stalled consumer
    rd_rsp_ready = 1'b0; rd_req_valid = 1'b1; idx = 0; rd_req_addr = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (rd_fired) idx++;
      rd_req_addr = AW'(idx);
    end
    check("credit_accepts", 64'(idx), 64'd4);
    rd_rsp_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 6; i++) begin
      cycle();
      if (rd_fired) idx++;
      rd_req_addr = AW'(idx);
    end
    rd_req_valid = 1'b0;
    check("credit_total", 64'(idx), 64'd6);
    for (int i = 0; i < 6; i++) cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // Write priority over simultaneous read requests
    rd_req_valid = 1'b1; rd_req_addr = 5'd6; wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = AW'(5 + i); wr_data = 64'h1000 + 64'(i);
      cycle();
      check("prio_no_read", 64'(rd_fired), 64'd0);
    end
    wr_valid = 1'b0;
    cycle();
    check("prio_read_c4", 64'(rd_fired), 64'd1);
    rd_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Out-of-range write is dropped and read returns zero with its address
    wr_valid = 1'b1; wr_addr = 5'd20; wr_data = 64'hDEAD;
    cycle();
    wr_valid = 1'b0; rd_req_valid = 1'b1; rd_req_addr = 5'd20;
    cycle();
    rd_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Reset with reads outstanding: nothing may surface, full clear restarts
    rd_rsp_ready = 1'b0; rd_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_req_addr = AW'(i + 3);
      cycle();
    end
    rst = 1'b1; rd_req_valid = 1'b0;
    cycle();
    rst = 1'b0; rd_rsp_ready = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < DP + 4; i++) begin
      if (!rd_rsp_valid) low_seen = 1'b1;
      cycle();
    end
    check("rst_no_rsp", 64'(low_seen), 64'd1);
    check("rst_geo", 64'(geo_count), 64'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      wr_valid     = ($urandom_range(0, 9) < 3);
      wr_addr      = AW'($urandom_range(0, 19));
      wr_data      = {$urandom, $urandom};
      rd_req_valid = ($urandom_range(0, 1) == 1);
      rd_req_addr  = AW'($urandom_range(0, 19));
      rd_rsp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    idle_inputs();
    rd_rsp_ready = 1'b1;
    for (int i = 0; i < DP + 8; i++) cycle();
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
